// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } seg_state_t;

  localparam int SLOT_TICKS = 16;
  localparam int NDIG       = 4;

  // Segment order per entry is A,B,C,D,E,F,G (A in bit 6).
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  function automatic seg_state_t arb_next(input seg_state_t cur, input logic ra,
                                          input logic rb, input logic hold_ok);
    seg_state_t nxt;
    nxt = cur;
    case (cur)
      IDLE: begin
        if (ra)      nxt = OWN_A;
        else if (rb) nxt = OWN_B;
      end
      OWN_A: begin
        if (!ra) nxt = rb ? OWN_B : IDLE;
      end
      OWN_B: begin
        if (!rb)                nxt = ra ? OWN_A : IDLE;
        else if (ra && hold_ok) nxt = OWN_A;
      end
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to 7-segment (A..G) decoder.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit 7-segment scan controller: frame-coherent two-requester arbitration,
// per-slot dead time and PWM brightness, hex decode.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV    = 1000,
  parameter int DEAD_TICKS = 1,
  parameter int MIN_HOLD   = 4
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req_a_i,
  input  logic [15:0] val_a_i,
  input  logic        req_b_i,
  input  logic [15:0] val_b_i,
  input  logic [3:0]  brightness_i,
  input  logic [3:0]  blank_mask_i,
  input  logic [3:0]  dp_mask_i,
  output logic        grant_a_o,
  output logic        grant_b_o,
  output logic [7:0]  segments_o,
  output logic [3:0]  digit_o
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(MIN_HOLD);
  localparam logic [4:0]    DEAD       = 5'(DEAD_TICKS);

  logic [PW-1:0] presc_q;
  logic [3:0]    slot_q;
  logic [1:0]    dig_q;
  seg_state_t    state_q, state_d;
  logic [HW-1:0] hold_q, hold_sat;
  logic [15:0]   latched_q;
  logic          grant_a_q, grant_b_q;
  logic [7:0]    segments_q;
  logic [3:0]    digit_q;

  logic          tick, frame_end, lit;
  logic [3:0]    nibble;
  logic [6:0]    hex_seg;
  logic [4:0]    slot_ext;

  assign tick      = (presc_q == PRESC_LAST);
  assign frame_end = tick && (slot_q == 4'd15) && (dig_q == 2'd3);
  assign nibble    = latched_q[{dig_q, 2'b00} +: 4];
  assign slot_ext  = {1'b0, slot_q};
  assign lit       = (slot_ext >= DEAD) && ((slot_ext - DEAD) < {1'b0, brightness_i})
                     && !blank_mask_i[dig_q];

  seg_hex_decode u_hex (
    .nib_i (nibble),
    .seg_o (hex_seg)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      presc_q    <= '0;
      slot_q     <= '0;
      dig_q      <= '0;
      digit_q    <= '0;
      segments_q <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        slot_q <= slot_q + 1'b1;
        if (slot_q == 4'd15) dig_q <= dig_q + 1'b1;
      end
      digit_q    <= lit ? (4'b0001 << dig_q) : 4'b0000;
      segments_q <= lit ? {hex_seg, dp_mask_i[dig_q]} : 8'h00;
    end
  end

  // Hold counts completed frames, so the value used at a boundary includes the frame just ending.
  assign hold_sat = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
  assign state_d  = arb_next(state_q, req_a_i, req_b_i, hold_sat == HOLD_MAX);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      latched_q <= '0;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
    end else if (frame_end) begin
      state_q   <= state_d;
      hold_q    <= (state_d != state_q) ? '0 : hold_sat;
      grant_a_q <= (state_d == OWN_A);
      grant_b_q <= (state_d == OWN_B);
      case (state_d)
        OWN_A:   latched_q <= val_a_i;
        OWN_B:   latched_q <= val_b_i;
        default: ;
      endcase
    end
  end

  assign grant_a_o  = grant_a_q;
  assign grant_b_o  = grant_b_q;
  assign segments_o = segments_q;
  assign digit_o    = digit_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: vector table, directed corner sequences,
// and randomized traffic against a frame-level reference model.
module tb_seg_scan_ctrl;

  localparam int CLK_DIV = 2;
  localparam int DEAD    = 1;
  localparam int MINH    = 2;
  localparam int FRAME   = CLK_DIV * 16 * 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_a, req_b;
  logic [15:0] val_a, val_b;
  logic [3:0]  brightness, blank_mask, dp_mask;
  logic        grant_a, grant_b;
  logic [7:0]  segments;
  logic [3:0]  digit;

  int total = 0;
  int bad   = 0;

  seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .DEAD_TICKS(DEAD), .MIN_HOLD(MINH)) dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .req_a_i      (req_a),
    .val_a_i      (val_a),
    .req_b_i      (req_b),
    .val_b_i      (val_b),
    .brightness_i (brightness),
    .blank_mask_i (blank_mask),
    .dp_mask_i    (dp_mask),
    .grant_a_o    (grant_a),
    .grant_b_o    (grant_b),
    .segments_o   (segments),
    .digit_o      (digit)
  );

  initial forever #5 clock = ~clock;

  function automatic logic [6:0] ref_hex(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;  default: return 7'b1000111;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: j = edges since reset; outputs reflect the scan position one edge earlier.
  int          j = 0;
  int          m_st = 0;   // 0 idle, 1 A owns, 2 B owns
  int          m_fr = 0;   // frames completed in current owner state
  logic [15:0] m_lat = '0;
  logic [3:0]  exp_dig = '0;
  logic [7:0]  exp_seg = '0;
  logic        exp_ga = 1'b0, exp_gb = 1'b0;
  bit          mdl_chk = 1'b0;

  initial forever begin
    int tt, ms, md, nst;
    @(posedge clock);
    if (reset) begin
      j = 0; m_st = 0; m_fr = 0; m_lat = '0;
      exp_dig = '0; exp_seg = '0; exp_ga = 1'b0; exp_gb = 1'b0;
    end else begin
      j++;
      tt = (j - 1) / CLK_DIV;
      ms = tt % 16;
      md = (tt / 16) % 4;
      if (ms >= DEAD && (ms - DEAD) < int'(brightness) && !blank_mask[md]) begin
        exp_dig = 4'(1 << md);
        exp_seg = {ref_hex(m_lat[4*md +: 4]), dp_mask[md]};
      end else begin
        exp_dig = '0;
        exp_seg = '0;
      end
      if (j % FRAME == 0) begin
        nst = m_st;
        if (m_st == 0)      nst = req_a ? 1 : (req_b ? 2 : 0);
        else if (m_st == 1) nst = req_a ? 1 : (req_b ? 2 : 0);
        else begin
          if (!req_b)                      nst = req_a ? 1 : 0;
          else if (req_a && m_fr + 1 >= MINH) nst = 1;
        end
        if (nst != m_st)     m_fr = 0;
        else if (m_fr < MINH) m_fr++;
        m_st = nst;
        if (m_st == 1) m_lat = val_a;
        if (m_st == 2) m_lat = val_b;
        exp_ga = (m_st == 1);
        exp_gb = (m_st == 2);
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (mdl_chk) begin
      check("mdl_digit", digit, exp_dig);
      check("mdl_segments", segments, exp_seg);
      check("mdl_grant_a", grant_a, exp_ga);
      check("mdl_grant_b", grant_b, exp_gb);
    end
  end

  task automatic wait_pos(input int d, input int s);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(j >= 1 && (((j - 1) / CLK_DIV) % 64) == 16 * d + s) && n < 400);
    if (n >= 400) begin
      total++; bad++;
      $display("FAIL wait_pos timeout: d=%0d s=%0d not reached", d, s);
    end
  endtask

  task automatic wait_edges(input int target);
    int n = 0;
    while (j != target && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 2000) begin
      total++; bad++;
      $display("FAIL wait_edges timeout: edge count %0d want %0d", j, target);
    end
  endtask

  typedef struct {
    logic [3:0] br;
    logic [3:0] blank;
    logic [3:0] dp;
    int         d;
    int         s;
    logic [3:0] dig;
    logic [7:0] seg;
  } vec_t;

  vec_t vt[14];

  initial begin
    // Value 16'h1234 owned by A: digit0 '4', digit1 '3', digit2 '2', digit3 '1'.
    vt[0]  = '{4'd4,  4'b0000, 4'b0000, 0, 0,  4'b0000, 8'h00};
    vt[1]  = '{4'd4,  4'b0000, 4'b0000, 0, 1,  4'b0001, 8'b01100110};
    vt[2]  = '{4'd4,  4'b0000, 4'b0000, 0, 4,  4'b0001, 8'b01100110};
    vt[3]  = '{4'd4,  4'b0000, 4'b0000, 0, 5,  4'b0000, 8'h00};
    vt[4]  = '{4'd4,  4'b0000, 4'b0000, 3, 2,  4'b1000, 8'b01100000};
    vt[5]  = '{4'd15, 4'b0000, 4'b0000, 1, 15, 4'b0010, 8'b11110010};
    vt[6]  = '{4'd15, 4'b0000, 4'b0000, 1, 0,  4'b0000, 8'h00};
    vt[7]  = '{4'd15, 4'b0000, 4'b0000, 2, 15, 4'b0100, 8'b11011010};
    vt[8]  = '{4'd0,  4'b0000, 4'b0000, 2, 1,  4'b0000, 8'h00};
    vt[9]  = '{4'd4,  4'b0100, 4'b0000, 2, 2,  4'b0000, 8'h00};
    vt[10] = '{4'd4,  4'b0100, 4'b0000, 1, 2,  4'b0010, 8'b11110010};
    vt[11] = '{4'd4,  4'b0000, 4'b0001, 0, 3,  4'b0001, 8'b01100111};
    vt[12] = '{4'd4,  4'b0000, 4'b0001, 1, 3,  4'b0010, 8'b11110010};
    vt[13] = '{4'd4,  4'b0000, 4'b0001, 0, 9,  4'b0000, 8'h00};

    reset = 1'b1; req_a = 1'b0; req_b = 1'b0; val_a = '0; val_b = '0;
    brightness = 4'd4; blank_mask = '0; dp_mask = '0;
    repeat (3) @(negedge clock);
    mdl_chk = 1'b1;
    check("reset_digit", digit, 4'b0000);
    check("reset_grant_a", grant_a, 1'b0);
    reset = 1'b0;

    // Idle after reset shows latched 0 on digit0 from s=1.
    wait_pos(0, 1);
    check("idle_digit0", digit, 4'b0001);
    check("idle_seg0", segments, 8'b11111100);

    // Simultaneous requests from IDLE: A wins.
    req_a = 1'b1; req_b = 1'b1; val_a = 16'h1234; val_b = 16'hABCD;
    wait_edges(FRAME);
    check("simul_grant_a", grant_a, 1'b1);
    check("simul_grant_b", grant_b, 1'b0);

    for (int i = 0; i < 14; i++) begin
      brightness = vt[i].br; blank_mask = vt[i].blank; dp_mask = vt[i].dp;
      wait_pos(vt[i].d, vt[i].s);
      check($sformatf("vec%0d_digit", i), digit, vt[i].dig);
      check($sformatf("vec%0d_seg", i), segments, vt[i].seg);
    end
    brightness = 4'd4; blank_mask = '0; dp_mask = '0;

    // Mid-frame value change is not shown until the next boundary.
    wait_pos(2, 0);
    val_a = 16'h5678;
    wait_pos(3, 2);
    check("tear_old_seg", segments, 8'b01100000);
    wait_pos(0, 1);
    check("tear_new_seg", segments, 8'b11111110);

    // Drop A with B still requesting: B takes over at the next boundary.
    req_a = 1'b0;
    wait_edges(j - (j % FRAME) + FRAME);
    check("handover_grant_b", grant_b, 1'b1);
    check("handover_grant_a", grant_a, 1'b0);

    // Reset while a digit is lit.
    wait_pos(1, 3);
    check("pre_reset_lit", digit, 4'b0010);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_digit", digit, 4'b0000);
    check("midrst_seg", segments, 8'h00);
    check("midrst_grant_a", grant_a, 1'b0);
    check("midrst_grant_b", grant_b, 1'b0);
    req_a = 1'b0; req_b = 1'b1; val_a = 16'h1234; val_b = 16'hBEEF;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("restart_d0", digit, 4'b0001);

    // B holds for MIN_HOLD frames before A may preempt.
    wait_edges(FRAME);
    check("b_entry_grant_b", grant_b, 1'b1);
    wait_pos(1, 0);
    req_a = 1'b1;
    wait_edges(2 * FRAME);
    check("b_hold_grant_b", grant_b, 1'b1);
    check("b_hold_grant_a", grant_a, 1'b0);
    wait_edges(3 * FRAME);
    check("preempt_grant_a", grant_a, 1'b1);
    check("preempt_grant_b", grant_b, 1'b0);
    wait_pos(0, 1);
    check("preempt_seg", segments, 8'b01100110);

    // Randomized traffic, checked continuously by the model.
    for (int c = 0; c < 8000; c++) begin
      @(negedge clock);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 2999) == 0) reset = 1'b1;
      if ($urandom_range(0, 149) == 0) req_a = ~req_a;
      if ($urandom_range(0, 149) == 0) req_b = ~req_b;
      if ($urandom_range(0, 39) == 0) val_a = 16'($urandom);
      if ($urandom_range(0, 39) == 0) val_b = 16'($urandom);
      if ($urandom_range(0, 29) == 0) brightness = 4'($urandom);
      if ($urandom_range(0, 59) == 0) blank_mask = 4'($urandom);
      if ($urandom_range(0, 59) == 0) dp_mask = 4'($urandom);
    end

    mdl_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
